avst_axis_bridge_pipe: RTL and testbench
========================================

// Module: avst_axis_bridge_pipe
// PURPOSE
//  Parametrised, registered bridge between AXI-S (tkeep/tlast) and AVST (sop/eop/empty) Ethernet streams.
//  RX path: AXI-S -> AVST. TX path: AVST -> AXI-S.
//  Reverses symbol order in both directions: AVST carries the first symbol in the high-order bits.
//  Optional 2-entry skid buffer per path. TX framing sanitiser. Saturating statistics counters.
//  Sits between the FIM Ethernet MAC interface and AFU packet logic.
// PARAMETERS
//  DATA_W   64  data width in bits; must be a multiple of SYM_W
//  SYM_W    8   symbol width; NSYM = DATA_W/SYM_W, EMPTY_W = $clog2(NSYM)
//  RX_REG   1   1: skid buffer on RX path (1-cycle latency); 0: combinational (0-cycle latency)
//  TX_REG   1   same as RX_REG, for the TX path
//  CNT_W    32  width of each statistics counter
// PORTS
//  clk                 in   1        clock for all logic
//  rst                 in   1        synchronous reset, active-high
//  rx_axis_tvalid      in   1        RX AXI-S valid
//  rx_axis_tready      out  1        RX AXI-S ready
//  rx_axis_tdata       in   DATA_W   RX data; first symbol in bits [SYM_W-1:0]
//  rx_axis_tkeep       in   NSYM     RX byte enables; contiguous from LSB
//  rx_axis_tlast       in   1        RX end of packet
//  rx_axis_tuser_err   in   1        RX packet error
//  rx_avst_valid/ready out/in 1      RX AVST handshake
//  rx_avst_data        out  DATA_W   RX data; first symbol in bits [DATA_W-1:DATA_W-SYM_W]
//  rx_avst_sop/eop     out  1        RX packet delimiters
//  rx_avst_empty       out  EMPTY_W  RX count of unused symbols on the eop beat
//  rx_avst_error       out  1        RX error
//  tx_avst_valid/ready in/out 1      TX AVST handshake
//  tx_avst_data        in   DATA_W   TX data
//  tx_avst_sop/eop     in   1        TX packet delimiters
//  tx_avst_empty       in   EMPTY_W  TX empty count
//  tx_avst_error       in   1        TX error
//  tx_axis_tvalid/tready out/in 1    TX AXI-S handshake
//  tx_axis_tdata       out  DATA_W   TX data
//  tx_axis_tkeep       out  NSYM     TX byte enables
//  tx_axis_tlast       out  1        TX end of packet
//  tx_axis_tuser_err   out  1        TX error
//  rx_pkt_cnt, tx_pkt_cnt, tx_drop_cnt, tx_frm_err_cnt   out  CNT_W   saturating statistics
// BEHAVIOUR
//  Reset values: all valid outputs 0; all counters 0; RX sop tracker = 1; TX framer state = IDLE.
//   *_ready outputs are 0 while rst=1 and 1 on the first cycle after rst falls.
//  Handshakes: a beat transfers when valid & ready. Once valid is asserted, outputs hold until accepted.
//   Skid buffer: full throughput (1 beat/clk). Upstream ready is registered (= buffer not full).
//  Data mapping: symbol i of tdata <-> symbol NSYM-1-i of AVST data.
//  RX empty: eop beat -> NSYM - popcount(tkeep); tkeep==0 gives 0. Non-eop beats -> 0.
//  RX sop: a register, set at reset, loaded with tlast on every accepted input beat;
//   rx_avst_sop = tracker & valid. rx_avst_eop = tlast; rx_avst_error = tuser_err.
//  TX tkeep: eop beat -> low (NSYM-empty) bits set. Non-eop beat -> all ones; empty ignored.
//  TX framer FSM (evaluated on each accepted AVST beat):
//   IDLE,   sop=0:        beat dropped (accepted, not forwarded); tx_drop_cnt++.
//   IDLE,   sop=1, eop=1: forward; stay IDLE; tx_pkt_cnt++.
//   IDLE,   sop=1, eop=0: forward; go to PKT; clear err_sticky.
//   PKT,    sop=1:        forward as continuation; err_sticky=1; tx_frm_err_cnt++.
//   PKT,    eop=1:        forward with tlast=1 and tuser_err = error|err_sticky; go to IDLE; tx_pkt_cnt++.
//   Beats accepted in the same cycle as sop+eop are handled by the IDLE row only; no double counting.
//  rx_pkt_cnt increments on each accepted output beat with eop=1.
//  Counters saturate at all-ones and do not wrap.
//  rst mid-packet: buffers flush; FSM -> IDLE; tracker -> 1. Any partial packet is lost, not terminated.
//  Latency: REG=1 -> output valid exactly 1 clk after input acceptance. REG=0 -> same cycle.
// TESTING
//  1 RX: DATA_W=64; 3-beat packet, last tkeep=8'h07 -> sop on beat0 only, eop on beat2, empty=5,
//    data bytes reversed.
//  2 TX: sop+eop single beat, empty=3 -> tkeep=8'h1F, tlast=1, tx_pkt_cnt=1.
//  3 TX: beat with sop=0 while IDLE -> no AXI-S output, tx_drop_cnt=1; following packet passes intact.
//  4 TX: sop, sop, eop sequence -> 3 beats out; last beat tuser_err=1; tx_frm_err_cnt=1; tx_pkt_cnt=1.
//  5 Backpressure: random tready/ready at 50% over 1000 beats -> no loss or duplication;
//    1 beat/clk when ready is held at 1.
//  6 Assert rst during beat 2 of 4 -> valids 0 next clk; the next packet's first beat has sop=1.

Source files
------------

// File: rtl/avst_axis_bridge_pipe.sv
// Registered bridge between AXI-S (tkeep/tlast) and AVST (sop/eop/empty) streams,
// with symbol reversal, optional skid buffers, TX framing sanitiser and saturating counters.
module avst_axis_bridge_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned RX_REG  = 1,
  parameter int unsigned TX_REG  = 1,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned NSYM    = DATA_W / SYM_W,
  localparam int unsigned EMPTY_W = $clog2(NSYM)
) (
  input  logic               clk,
  input  logic               rst,
  // RX: AXI-S in
  input  logic               rx_axis_tvalid,
  output logic               rx_axis_tready,
  input  logic [DATA_W-1:0]  rx_axis_tdata,
  input  logic [NSYM-1:0]    rx_axis_tkeep,
  input  logic               rx_axis_tlast,
  input  logic               rx_axis_tuser_err,
  // RX: AVST out
  output logic               rx_avst_valid,
  input  logic               rx_avst_ready,
  output logic [DATA_W-1:0]  rx_avst_data,
  output logic               rx_avst_sop,
  output logic               rx_avst_eop,
  output logic [EMPTY_W-1:0] rx_avst_empty,
  output logic               rx_avst_error,
  // TX: AVST in
  input  logic               tx_avst_valid,
  output logic               tx_avst_ready,
  input  logic [DATA_W-1:0]  tx_avst_data,
  input  logic               tx_avst_sop,
  input  logic               tx_avst_eop,
  input  logic [EMPTY_W-1:0] tx_avst_empty,
  input  logic               tx_avst_error,
  // TX: AXI-S out
  output logic               tx_axis_tvalid,
  input  logic               tx_axis_tready,
  output logic [DATA_W-1:0]  tx_axis_tdata,
  output logic [NSYM-1:0]    tx_axis_tkeep,
  output logic               tx_axis_tlast,
  output logic               tx_axis_tuser_err,
  // statistics
  output logic [CNT_W-1:0]   rx_pkt_cnt,
  output logic [CNT_W-1:0]   tx_pkt_cnt,
  output logic [CNT_W-1:0]   tx_drop_cnt,
  output logic [CNT_W-1:0]   tx_frm_err_cnt
);

  localparam int unsigned RXP_W = DATA_W + EMPTY_W + 3;
  localparam int unsigned TXP_W = DATA_W + NSYM + 2;
  localparam logic [EMPTY_W:0]  NSYM_E   = NSYM[EMPTY_W:0];
  localparam logic [NSYM-1:0]   KEEP_ALL = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_PKT} tx_state_e;

  function automatic logic [DATA_W-1:0] rev_syms(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NSYM; i++)
      r[(NSYM-1-i)*SYM_W +: SYM_W] = d[i*SYM_W +: SYM_W];
    return r;
  endfunction

  // ---------------- RX path ----------------
  logic               rx_sop_q;
  logic               rx_in_fire;
  logic [EMPTY_W:0]   rx_pop;
  logic [EMPTY_W:0]   rx_empty_w;
  logic [EMPTY_W-1:0] rx_in_empty;
  logic [RXP_W-1:0]   rx_in_pl;
  logic [RXP_W-1:0]   rx_out_pl;
  logic               rx_sop_raw;
  logic [CNT_W-1:0]   rx_pkt_cnt_q;

  assign rx_in_fire = rx_axis_tvalid & rx_axis_tready;

  always_comb begin
    rx_pop = '0;
    for (int unsigned i = 0; i < NSYM; i++)
      rx_pop = rx_pop + {{EMPTY_W{1'b0}}, rx_axis_tkeep[i]};
    rx_empty_w  = '0;
    if (rx_axis_tlast && (rx_axis_tkeep != '0))
      rx_empty_w = NSYM_E - rx_pop;
    rx_in_empty = rx_empty_w[EMPTY_W-1:0];
  end

  // sop travels with the beat so it stays aligned through the skid buffer
  assign rx_in_pl = {rev_syms(rx_axis_tdata), rx_sop_q, rx_axis_tlast, rx_in_empty, rx_axis_tuser_err};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sop_q     <= 1'b1;
      rx_pkt_cnt_q <= '0;
    end else begin
      if (rx_in_fire)
        rx_sop_q <= rx_axis_tlast;
      if (rx_avst_valid && rx_avst_ready && rx_avst_eop && (rx_pkt_cnt_q != '1))
        rx_pkt_cnt_q <= rx_pkt_cnt_q + CNT_ONE;
    end
  end

  generate
    if (RX_REG != 0) begin : g_rx_skid
      logic             out_v_q, skid_v_q;
      logic [RXP_W-1:0] out_q, skid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          out_v_q  <= 1'b0;
          skid_v_q <= 1'b0;
        end else if (!out_v_q || rx_avst_ready) begin
          if (skid_v_q) begin
            out_v_q  <= 1'b1;
            out_q    <= skid_q;
            skid_v_q <= 1'b0;
          end else begin
            out_v_q <= rx_in_fire;
            out_q   <= rx_in_pl;
          end
        end else if (rx_in_fire) begin
          skid_v_q <= 1'b1;
          skid_q   <= rx_in_pl;
        end
      end
      assign rx_axis_tready = ~skid_v_q & ~rst;
      assign rx_avst_valid  = out_v_q;
      assign rx_out_pl      = out_q;
    end else begin : g_rx_comb
      assign rx_axis_tready = rx_avst_ready & ~rst;
      assign rx_avst_valid  = rx_axis_tvalid & ~rst;
      assign rx_out_pl      = rx_in_pl;
    end
  endgenerate

  assign {rx_avst_data, rx_sop_raw, rx_avst_eop, rx_avst_empty, rx_avst_error} = rx_out_pl;
  assign rx_avst_sop = rx_sop_raw & rx_avst_valid;
  assign rx_pkt_cnt  = rx_pkt_cnt_q;

  // ---------------- TX path ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic             tx_sticky_q, tx_sticky_d;
  logic             tx_in_fire, tx_push;
  logic             tx_fwd, tx_last, tx_err;
  logic             inc_pkt, inc_drop, inc_frm;
  logic [NSYM-1:0]  tx_keep;
  logic [TXP_W-1:0] tx_in_pl;
  logic [TXP_W-1:0] tx_out_pl;
  logic [CNT_W-1:0] tx_pkt_cnt_q, tx_drop_cnt_q, tx_frm_err_cnt_q;

  assign tx_in_fire = tx_avst_valid & tx_avst_ready;
  assign tx_push    = tx_in_fire & tx_fwd;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_sticky_d = tx_sticky_q;
    tx_fwd      = 1'b1;
    tx_last     = 1'b0;
    tx_err      = tx_avst_error;
    inc_pkt     = 1'b0;
    inc_drop    = 1'b0;
    inc_frm     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_avst_sop) begin
          tx_fwd   = 1'b0;
          inc_drop = 1'b1;
        end else if (tx_avst_eop) begin
          tx_last = 1'b1;
          inc_pkt = 1'b1;
        end else begin
          tx_state_d  = S_PKT;
          tx_sticky_d = 1'b0;
        end
      end
      S_PKT: begin
        // a stray sop inside a packet marks it bad; a sop+eop here also closes it
        if (tx_avst_sop) begin
          tx_sticky_d = 1'b1;
          inc_frm     = 1'b1;
        end
        if (tx_avst_eop) begin
          tx_last    = 1'b1;
          tx_err     = tx_avst_error | tx_sticky_d;
          tx_state_d = S_IDLE;
          inc_pkt    = 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    tx_keep = tx_last ? (KEEP_ALL >> tx_avst_empty) : KEEP_ALL;
  end

  assign tx_in_pl = {rev_syms(tx_avst_data), tx_keep, tx_last, tx_err};

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q       <= S_IDLE;
      tx_sticky_q      <= 1'b0;
      tx_pkt_cnt_q     <= '0;
      tx_drop_cnt_q    <= '0;
      tx_frm_err_cnt_q <= '0;
    end else if (tx_in_fire) begin
      tx_state_q  <= tx_state_d;
      tx_sticky_q <= tx_sticky_d;
      if (inc_pkt && (tx_pkt_cnt_q != '1))
        tx_pkt_cnt_q <= tx_pkt_cnt_q + CNT_ONE;
      if (inc_drop && (tx_drop_cnt_q != '1))
        tx_drop_cnt_q <= tx_drop_cnt_q + CNT_ONE;
      if (inc_frm && (tx_frm_err_cnt_q != '1))
        tx_frm_err_cnt_q <= tx_frm_err_cnt_q + CNT_ONE;
    end
  end

  generate
    if (TX_REG != 0) begin : g_tx_skid
      logic             out_v_q, skid_v_q;
      logic [TXP_W-1:0] out_q, skid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          out_v_q  <= 1'b0;
          skid_v_q <= 1'b0;
        end else if (!out_v_q || tx_axis_tready) begin
          if (skid_v_q) begin
            out_v_q  <= 1'b1;
            out_q    <= skid_q;
            skid_v_q <= 1'b0;
          end else begin
            out_v_q <= tx_push;
            out_q   <= tx_in_pl;
          end
        end else if (tx_push) begin
          skid_v_q <= 1'b1;
          skid_q   <= tx_in_pl;
        end
      end
      assign tx_avst_ready  = ~skid_v_q & ~rst;
      assign tx_axis_tvalid = out_v_q;
      assign tx_out_pl      = out_q;
    end else begin : g_tx_comb
      assign tx_avst_ready  = tx_axis_tready & ~rst;
      assign tx_axis_tvalid = tx_avst_valid & tx_fwd & ~rst;
      assign tx_out_pl      = tx_in_pl;
    end
  endgenerate

  assign {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser_err} = tx_out_pl;
  assign tx_pkt_cnt     = tx_pkt_cnt_q;
  assign tx_drop_cnt    = tx_drop_cnt_q;
  assign tx_frm_err_cnt = tx_frm_err_cnt_q;

endmodule

// File: tb/tb_avst_axis_bridge_pipe.sv
// Directed vector tables for RX/TX mapping and framing, plus throughput,
// random backpressure and mid-packet reset sequences.
module tb_avst_axis_bridge_pipe;

  logic        clk, rst;
  logic        rx_axis_tvalid, rx_axis_tready, rx_axis_tlast, rx_axis_tuser_err;
  logic [63:0] rx_axis_tdata;
  logic [7:0]  rx_axis_tkeep;
  logic        rx_avst_valid, rx_avst_ready, rx_avst_sop, rx_avst_eop, rx_avst_error;
  logic [63:0] rx_avst_data;
  logic [2:0]  rx_avst_empty;
  logic        tx_avst_valid, tx_avst_ready, tx_avst_sop, tx_avst_eop, tx_avst_error;
  logic [63:0] tx_avst_data;
  logic [2:0]  tx_avst_empty;
  logic        tx_axis_tvalid, tx_axis_tready, tx_axis_tlast, tx_axis_tuser_err;
  logic [63:0] tx_axis_tdata;
  logic [7:0]  tx_axis_tkeep;
  logic [31:0] rx_pkt_cnt, tx_pkt_cnt, tx_drop_cnt, tx_frm_err_cnt;

  avst_axis_bridge_pipe #(.DATA_W(64), .SYM_W(8), .RX_REG(1), .TX_REG(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(rx_axis_tready),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser_err(rx_axis_tuser_err),
    .rx_avst_valid(rx_avst_valid), .rx_avst_ready(rx_avst_ready),
    .rx_avst_data(rx_avst_data), .rx_avst_sop(rx_avst_sop), .rx_avst_eop(rx_avst_eop),
    .rx_avst_empty(rx_avst_empty), .rx_avst_error(rx_avst_error),
    .tx_avst_valid(tx_avst_valid), .tx_avst_ready(tx_avst_ready),
    .tx_avst_data(tx_avst_data), .tx_avst_sop(tx_avst_sop), .tx_avst_eop(tx_avst_eop),
    .tx_avst_empty(tx_avst_empty), .tx_avst_error(tx_avst_error),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
    .tx_axis_tlast(tx_axis_tlast), .tx_axis_tuser_err(tx_axis_tuser_err),
    .rx_pkt_cnt(rx_pkt_cnt), .tx_pkt_cnt(tx_pkt_cnt),
    .tx_drop_cnt(tx_drop_cnt), .tx_frm_err_cnt(tx_frm_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d; logic [7:0] keep; logic last; logic err;
    logic [63:0] xd; logic xsop; logic xeop; logic [2:0] xempty; logic xerr;
  } rx_vec_t;

  typedef struct packed {
    logic [63:0] d; logic sop; logic eop; logic [2:0] empty; logic err;
    logic xfwd; logic [63:0] xd; logic [7:0] xkeep; logic xlast; logic xerr;
  } tx_vec_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[(7-i)*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  rx_vec_t rxv[8];
  tx_vec_t txv[11];
  logic [79:0] rxq[$];
  logic [79:0] txq[$];

  initial begin
    logic [79:0] e;
    logic        rx_m_sop, tx_m_sop, rx_f, tx_f;
    int unsigned rx_sent, rx_rcvd, tx_sent, tx_rcvd, cyc;

    rxv[0] = '{64'h0706050403020100, 8'hFF, 1'b0, 1'b0, 64'h0001020304050607, 1'b1, 1'b0, 3'd0, 1'b0};
    rxv[1] = '{64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0, 64'h08090A0B0C0D0E0F, 1'b0, 1'b0, 3'd0, 1'b0};
    rxv[2] = '{64'h1716151413121110, 8'h07, 1'b1, 1'b0, 64'h1011121314151617, 1'b0, 1'b1, 3'd5, 1'b0};
    rxv[3] = '{64'hDEADBEEF01234567, 8'hFF, 1'b1, 1'b1, 64'h67452301EFBEADDE, 1'b1, 1'b1, 3'd0, 1'b1};
    rxv[4] = '{64'h1122334455667788, 8'h00, 1'b1, 1'b0, 64'h8877665544332211, 1'b1, 1'b1, 3'd0, 1'b0};
    rxv[5] = '{64'h00000000000000AA, 8'h01, 1'b1, 1'b0, 64'hAA00000000000000, 1'b1, 1'b1, 3'd7, 1'b0};
    rxv[6] = '{64'h0000000000000000, 8'h0F, 1'b0, 1'b0, 64'h0000000000000000, 1'b1, 1'b0, 3'd0, 1'b0};
    rxv[7] = '{64'h000000000000003C, 8'h3F, 1'b1, 1'b0, 64'h3C00000000000000, 1'b0, 1'b1, 3'd2, 1'b0};

    txv[0]  = '{64'h0001020304050607, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 64'h0706050403020100, 8'h1F, 1'b1, 1'b0};
    txv[1]  = '{64'h000000000000FFFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0};
    txv[2]  = '{64'h1111111122222222, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 64'h2222222211111111, 8'hFF, 1'b0, 1'b0};
    txv[3]  = '{64'h0123456789ABCDEF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 64'hEFCDAB8967452301, 8'hFF, 1'b1, 1'b0};
    txv[4]  = '{64'h00000000000000A0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 64'hA000000000000000, 8'hFF, 1'b0, 1'b0};
    txv[5]  = '{64'h00000000000000B0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 64'hB000000000000000, 8'hFF, 1'b0, 1'b0};
    txv[6]  = '{64'h00000000000000C0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 64'hC000000000000000, 8'h01, 1'b1, 1'b1};
    txv[7]  = '{64'h00000000000000D0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 64'hD000000000000000, 8'hFF, 1'b1, 1'b1};
    txv[8]  = '{64'h00000000000000E0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0};
    txv[9]  = '{64'h00000000000000F0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 64'hF000000000000000, 8'hFF, 1'b0, 1'b0};
    txv[10] = '{64'h000000000000000F, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 64'h0F00000000000000, 8'h7F, 1'b1, 1'b0};

    rst = 1'b1;
    rx_axis_tvalid = 0; rx_axis_tdata = '0; rx_axis_tkeep = '0; rx_axis_tlast = 0; rx_axis_tuser_err = 0;
    tx_avst_valid = 0; tx_avst_data = '0; tx_avst_sop = 0; tx_avst_eop = 0; tx_avst_empty = '0; tx_avst_error = 0;
    rx_avst_ready = 1; tx_axis_tready = 1;
    tick(); tick(); tick();

    // reset state
    chk("rst_rx_tready", rx_axis_tready, 0);
    chk("rst_tx_ready", tx_avst_ready, 0);
    chk("rst_rx_valid", rx_avst_valid, 0);
    chk("rst_tx_valid", tx_axis_tvalid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rx_tready", rx_axis_tready, 1);
    chk("post_rst_tx_ready", tx_avst_ready, 1);
    chk("rst_counters", {rx_pkt_cnt, tx_pkt_cnt, tx_drop_cnt, tx_frm_err_cnt}, '0);
    tick();

    // RX table: one beat per vector, output checked one clock after acceptance
    for (int i = 0; i < 8; i++) begin
      rx_axis_tvalid = 1; rx_axis_tdata = rxv[i].d; rx_axis_tkeep = rxv[i].keep;
      rx_axis_tlast = rxv[i].last; rx_axis_tuser_err = rxv[i].err;
      tick();
      rx_axis_tvalid = 0;
      chk($sformatf("rx_vec%0d_valid", i), rx_avst_valid, 1);
      chk($sformatf("rx_vec%0d_data", i), rx_avst_data, rxv[i].xd);
      chk($sformatf("rx_vec%0d_ctl", i), {rx_avst_sop, rx_avst_eop, rx_avst_empty, rx_avst_error},
          {rxv[i].xsop, rxv[i].xeop, rxv[i].xempty, rxv[i].xerr});
    end
    tick();
    chk("rx_pkt_cnt", rx_pkt_cnt, 5);
    chk("rx_idle_valid", rx_avst_valid, 0);

    // TX table
    for (int i = 0; i < 11; i++) begin
      tx_avst_valid = 1; tx_avst_data = txv[i].d; tx_avst_sop = txv[i].sop;
      tx_avst_eop = txv[i].eop; tx_avst_empty = txv[i].empty; tx_avst_error = txv[i].err;
      tick();
      tx_avst_valid = 0;
      chk($sformatf("tx_vec%0d_valid", i), tx_axis_tvalid, txv[i].xfwd);
      if (txv[i].xfwd) begin
        chk($sformatf("tx_vec%0d_data", i), tx_axis_tdata, txv[i].xd);
        chk($sformatf("tx_vec%0d_ctl", i), {tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser_err},
            {txv[i].xkeep, txv[i].xlast, txv[i].xerr});
      end
    end
    chk("tx_pkt_cnt", tx_pkt_cnt, 5);
    chk("tx_drop_cnt", tx_drop_cnt, 2);
    chk("tx_frm_err_cnt", tx_frm_err_cnt, 1);
    tick();

    // RX throughput: 16 back-to-back beats with ready held high
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("thru_tready%0d", i), rx_axis_tready, 1);
      rx_axis_tvalid = 1; rx_axis_tdata = 64'(i + 1); rx_axis_tkeep = 8'hFF;
      rx_axis_tlast = (i == 15); rx_axis_tuser_err = 0;
      tick();
      chk($sformatf("thru_beat%0d", i), {rx_avst_valid, rx_avst_data}, {1'b1, 8'(i + 1), 56'h0});
    end
    rx_axis_tvalid = 0;
    tick();

    // random backpressure on both paths
    rx_m_sop = 1; tx_m_sop = 1;
    rx_sent = 0; rx_rcvd = 0; tx_sent = 0; tx_rcvd = 0; cyc = 0;
    while ((rx_rcvd < 1000 || tx_rcvd < 1000) && cyc < 20000) begin
      cyc++;
      if (!rx_axis_tvalid && rx_sent < 1000 && $urandom_range(1, 0) == 1) begin
        rx_axis_tvalid = 1; rx_axis_tdata = {$urandom, $urandom};
        rx_axis_tlast = ($urandom_range(3, 0) == 0);
        rx_axis_tkeep = rx_axis_tlast ? (8'hFF >> $urandom_range(8, 0)) : 8'hFF;
        rx_axis_tuser_err = $urandom_range(1, 0);
      end
      if (!tx_avst_valid && tx_sent < 1000 && $urandom_range(1, 0) == 1) begin
        tx_avst_valid = 1; tx_avst_data = {$urandom, $urandom}; tx_avst_sop = tx_m_sop;
        tx_avst_eop = ($urandom_range(3, 0) == 0); tx_avst_empty = 3'($urandom_range(7, 0));
        tx_avst_error = $urandom_range(1, 0);
      end
      rx_avst_ready = $urandom_range(1, 0);
      tx_axis_tready = $urandom_range(1, 0);
      #1;
      rx_f = rx_axis_tvalid & rx_axis_tready;
      tx_f = tx_avst_valid & tx_avst_ready;
      if (rx_avst_valid && rx_avst_ready) begin
        if (rxq.size() == 0) chk("rx_stream_extra", 1, 0);
        else begin
          e = rxq.pop_front();
          chk($sformatf("rx_stream%0d", rx_rcvd),
              {10'h0, rx_avst_data, rx_avst_sop, rx_avst_eop, rx_avst_empty, rx_avst_error}, e);
        end
        rx_rcvd++;
      end
      if (tx_axis_tvalid && tx_axis_tready) begin
        if (txq.size() == 0) chk("tx_stream_extra", 1, 0);
        else begin
          e = txq.pop_front();
          chk($sformatf("tx_stream%0d", tx_rcvd),
              {6'h0, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser_err}, e);
        end
        tx_rcvd++;
      end
      if (rx_f) begin
        rxq.push_back({10'h0, rev64(rx_axis_tdata), rx_m_sop, rx_axis_tlast,
                       (rx_axis_tlast && rx_axis_tkeep != 0) ? 3'(8 - $countones(rx_axis_tkeep)) : 3'd0,
                       rx_axis_tuser_err});
        rx_m_sop = rx_axis_tlast;
        rx_sent++;
      end
      if (tx_f) begin
        txq.push_back({6'h0, rev64(tx_avst_data), tx_avst_eop ? (8'hFF >> tx_avst_empty) : 8'hFF,
                       tx_avst_eop, tx_avst_error});
        tx_m_sop = tx_avst_eop;
        tx_sent++;
      end
      @(posedge clk);
      #1;
      if (rx_f) rx_axis_tvalid = 0;
      if (tx_f) tx_avst_valid = 0;
    end
    chk("rx_stream_count", rx_rcvd, 1000);
    chk("tx_stream_count", tx_rcvd, 1000);
    chk("stream_leftover", rxq.size() + txq.size(), 0);

    rx_axis_tvalid = 0; tx_avst_valid = 0; rx_avst_ready = 1; tx_axis_tready = 1;
    tick(); tick(); tick();

    // reset during beat 2 of a 4-beat packet
    tx_avst_valid = 1; tx_avst_sop = 1; tx_avst_eop = 0; tx_avst_data = 64'h55;
    rx_axis_tvalid = 1; rx_axis_tdata = 64'h10; rx_axis_tkeep = 8'hFF; rx_axis_tlast = 0;
    tick();
    tx_avst_valid = 0; rx_axis_tdata = 64'h11;
    tick();
    rx_axis_tdata = 64'h12; rst = 1;
    tick();
    chk("mid_rst_rx_valid", rx_avst_valid, 0);
    chk("mid_rst_tx_valid", tx_axis_tvalid, 0);
    chk("mid_rst_rx_tready", rx_axis_tready, 0);
    rst = 0; rx_axis_tvalid = 0;
    #1;
    chk("mid_rst_ready_back", {rx_axis_tready, tx_avst_ready}, 2'b11);
    chk("mid_rst_counters", {rx_pkt_cnt, tx_pkt_cnt, tx_drop_cnt, tx_frm_err_cnt}, '0);
    tick();
    rx_axis_tvalid = 1; rx_axis_tdata = 64'h20; rx_axis_tlast = 0;
    tx_avst_valid = 1; tx_avst_sop = 0; tx_avst_eop = 1; tx_avst_data = 64'h66;
    tick();
    rx_axis_tvalid = 0; tx_avst_valid = 0;
    chk("post_rst_rx_sop", {rx_avst_valid, rx_avst_sop, rx_avst_data}, {2'b11, 64'h2000000000000000});
    chk("post_rst_tx_dropped", tx_axis_tvalid, 0);
    chk("post_rst_drop_cnt", tx_drop_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
